// File: rtl/operand_fetch.sv
// operand_fetch: decode/operand-fetch stage wrapped around the BR bank.
// Define OPERAND_FETCH_BYPASS_EN to compile in the write-port bypass.
module operand_fetch #(
  parameter int XLEN    = 32,
  parameter bit ZERO_X0 = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic [4:0]      a1,
  output logic [4:0]      a2,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  input  logic            wb_we,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [31:0]     out_instr
);

  typedef enum logic [1:0] {IDLE, READ, VALID} state_t;

  state_t          state, state_nx;
  logic            accept;
  logic [31:0]     instr_q;
  logic [4:0]      rs1, rs2;
  logic [XLEN-1:0] rs1_sel, rs2_sel;

  function automatic logic [31:0] imm_of(input logic [31:0] i);
    logic [6:0] op;
    op = i[6:0];
    imm_of = '0;
    unique case (1'b1)
      (op == 7'b0010011 || op == 7'b0000011 || op == 7'b1100111):
        imm_of = {{20{i[31]}}, i[31:20]};
      (op == 7'b0100011):
        imm_of = {{20{i[31]}}, i[31:25], i[11:7]};
      (op == 7'b1100011):
        imm_of = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      (op == 7'b0110111 || op == 7'b0010111):
        imm_of = {i[31:12], 12'b0};
      (op == 7'b1101111):
        imm_of = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default:
        imm_of = '0;
    endcase
  endfunction

  assign a1 = in_instr[19:15];
  assign a2 = in_instr[24:20];
  assign rs1 = instr_q[19:15];
  assign rs2 = instr_q[24:20];
  assign out_valid = (state == VALID);
  assign accept = in_valid && in_ready;

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = READ;
      end
      READ: state_nx = VALID;
      VALID: begin
        in_ready = out_ready;
        if (out_ready) state_nx = in_valid ? READ : IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (rst) in_ready = 1'b0;
  end

`ifdef OPERAND_FETCH_BYPASS_EN
  // The bank returns the pre-write value for a write at the accept edge.
  logic            e0_we;
  logic [4:0]      e0_addr;
  logic [XLEN-1:0] e0_data;
  logic [4:0]      hs1, hs2;
  logic            upd1, upd2;

  always_ff @(posedge clk) begin
    if (rst) begin
      e0_we   <= 1'b0;
      e0_addr <= '0;
      e0_data <= '0;
    end else if (accept) begin
      e0_we   <= wb_we;
      e0_addr <= wb_addr;
      e0_data <= wb_data;
    end
  end

  assign hs1 = out_instr[19:15];
  assign hs2 = out_instr[24:20];
  assign upd1 = (state == VALID) && !out_ready && wb_we &&
                (wb_addr == hs1) && !(ZERO_X0 && hs1 == 5'd0);
  assign upd2 = (state == VALID) && !out_ready && wb_we &&
                (wb_addr == hs2) && !(ZERO_X0 && hs2 == 5'd0);
`else
  logic unused_wb;
  assign unused_wb = ^{wb_we, wb_addr, wb_data};
`endif

  always_comb begin
    rs1_sel = rd1;
    rs2_sel = rd2;
`ifdef OPERAND_FETCH_BYPASS_EN
    if (e0_we && e0_addr == rs1) rs1_sel = e0_data;
    if (e0_we && e0_addr == rs2) rs2_sel = e0_data;
    if (wb_we && wb_addr == rs1) rs1_sel = wb_data;
    if (wb_we && wb_addr == rs2) rs2_sel = wb_data;
`endif
    if (ZERO_X0 && rs1 == 5'd0) rs1_sel = '0;
    if (ZERO_X0 && rs2 == 5'd0) rs2_sel = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      instr_q     <= '0;
      out_rs1_val <= '0;
      out_rs2_val <= '0;
      out_rd      <= '0;
      out_imm     <= '0;
      out_instr   <= '0;
    end else begin
      state <= state_nx;
      if (accept) instr_q <= in_instr;
      if (state == READ) begin
        out_rs1_val <= rs1_sel;
        out_rs2_val <= rs2_sel;
        out_rd      <= instr_q[11:7];
        out_imm     <= XLEN'($signed(imm_of(instr_q)));
        out_instr   <= instr_q;
      end
`ifdef OPERAND_FETCH_BYPASS_EN
      if (upd1) out_rs1_val <= wb_data;
      if (upd2) out_rs2_val <= wb_data;
`endif
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: random and directed checks of operand_fetch against
// a transaction-level model driven by an architectural register file.
module tb_operand_fetch;
  localparam int XLEN = 32;
  localparam logic [31:0] ADDI  = 32'hFFC28313;
  localparam logic [31:0] ADD   = 32'h005283B3;
  localparam logic [31:0] ADDX0 = 32'h000000B3;
  localparam logic [31:0] BEQ   = 32'hFE000EE3;
  localparam logic [6:0] OPS [10] = '{7'b0010011, 7'b0000011, 7'b1100111,
    7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
    7'b0110011, 7'b1110011};
`ifdef OPERAND_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, wb_we;
  logic [31:0] in_instr, out_instr;
  logic [4:0] a1, a2, wb_addr, out_rd;
  logic [XLEN-1:0] rd1, rd2, wb_data, out_rs1_val, out_rs2_val, out_imm;
  logic [XLEN-1:0] bank [32];

  int n_vec = 0;
  int n_bad = 0;

  bit m_have = 1'b0;
  bit m_pend = 1'b0;
  bit m_zero = 1'b1;
  bit exp_rdy;
  logic [31:0] m_instr, m_pinstr;
  logic [31:0] m_s1, m_s2, m_ps1, m_ps2;

  always #5 clk = ~clk;

  // Bank: registered read of the old value, write on the same edge.
  always @(posedge clk) begin
    rd1 <= bank[a1];
    rd2 <= bank[a2];
    if (wb_we) bank[wb_addr] <= wb_data;
  end

  operand_fetch #(.XLEN(XLEN), .ZERO_X0(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_rd(out_rd), .out_imm(out_imm), .out_instr(out_instr)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_imm(logic [31:0] i);
    case (i[6:0])
      7'b0010011, 7'b0000011, 7'b1100111:
        return 32'($signed(i) >>> 20);
      7'b0100011:
        return 32'($signed({i[31:25], i[11:7], 20'b0}) >>> 20);
      7'b1100011:
        return 32'($signed({i[31], i[7], i[30:25], i[11:8], 20'b0}) >>> 19);
      7'b0110111, 7'b0010111:
        return {i[31:12], 12'b0};
      7'b1101111:
        return 32'($signed({i[31], i[19:12], i[20], i[30:21], 12'b0}) >>> 11);
      default:
        return 32'b0;
    endcase
  endfunction

  // With bypass an operand tracks the register file; without it, the
  // value is the one the bank held just before the accept edge.
  function automatic logic [31:0] ref_op(logic [4:0] rs, logic [31:0] snap);
    if (rs == 5'd0) return 32'b0;
    return BYP ? bank[rs] : snap;
  endfunction

  task automatic cyc(bit r, bit iv, logic [31:0] ins, bit ordy,
                     bit we, logic [4:0] wa, logic [31:0] wd);
    bit acc;
    rst = r; in_valid = iv; in_instr = ins; out_ready = ordy;
    wb_we = we; wb_addr = wa; wb_data = wd;
    #1;
    exp_rdy = !r && !m_pend && (!m_have || ordy);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("a1a2", {22'b0, a1, a2}, {22'b0, ins[19:15], ins[24:20]});
    acc = iv && exp_rdy;
    if (r) begin
      m_have = 1'b0; m_pend = 1'b0; m_zero = 1'b1;
    end else begin
      if (m_pend) begin
        m_have = 1'b1; m_zero = 1'b0;
        m_instr = m_pinstr; m_s1 = m_ps1; m_s2 = m_ps2;
      end else if (ordy) begin
        m_have = 1'b0;
      end
      m_pend = acc;
      if (acc) begin
        m_pinstr = ins;
        m_ps1 = bank[ins[19:15]];
        m_ps2 = bank[ins[24:20]];
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(m_have));
    if (m_have) begin
      chk("rs1_val", out_rs1_val, ref_op(m_instr[19:15], m_s1));
      chk("rs2_val", out_rs2_val, ref_op(m_instr[24:20], m_s2));
      chk("rd", 32'(out_rd), 32'(m_instr[11:7]));
      chk("imm", out_imm, ref_imm(m_instr));
      chk("instr", out_instr, m_instr);
    end else if (m_zero) begin
      chk("zero_outs", out_rs1_val | out_rs2_val | out_imm | out_instr |
          32'(out_rd), 32'b0);
    end
  endtask

  initial begin
    logic [31:0] ins;
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    @(negedge clk);
    for (int k = 0; k < 32; k++)
      cyc(1'b1, 1'b1, ADDI, 1'b1, 1'b1, 5'(k),
          k == 0 ? 32'hDEAD : (k == 5 ? 32'h11 : $urandom));
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("rdy_after_rst", 32'(in_ready), 32'd1);

    cyc(0, 1, ADDI, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_rs1", out_rs1_val, 32'h11);
    chk("addi_imm", out_imm, 32'hFFFFFFFC);
    chk("addi_rd", 32'(out_rd), 32'd6);
    cyc(0, 0, 0, 1, 0, 0, 0);

    cyc(0, 1, ADD, 0, 1, 5, 32'h22);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("e0_rs1", out_rs1_val, BYP ? 32'h22 : 32'h11);
    chk("e0_rs2", out_rs2_val, BYP ? 32'h22 : 32'h11);
    cyc(0, 0, 0, 1, 0, 0, 0);

    cyc(0, 1, ADD, 0, 1, 5, 32'h66);
    cyc(0, 0, 0, 0, 1, 5, 32'h33);
    chk("e1_rs1", out_rs1_val, BYP ? 32'h33 : 32'h22);

    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 5, 32'h44);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("hold_rs1", out_rs1_val, BYP ? 32'h44 : 32'h22);
    chk("hold_rd", 32'(out_rd), 32'd7);
    chk("hold_instr", out_instr, ADD);
    chk("hold_imm", out_imm, 32'd0);
    cyc(0, 1, ADDI, 1, 0, 0, 0);
    chk("b2b_read", 32'(out_valid), 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("b2b_rs1", out_rs1_val, 32'h44);
    chk("b2b_imm", out_imm, 32'hFFFFFFFC);

    cyc(0, 1, ADDX0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("x0_rs1", out_rs1_val, 32'd0);
    chk("x0_rs2", out_rs2_val, 32'd0);
    cyc(0, 1, BEQ, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("beq_imm", out_imm, 32'hFFFFFFFC);
    cyc(0, 0, 0, 1, 0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      ins = $urandom;
      ins[6:0] = OPS[$urandom_range(0, 9)];
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, ins,
          $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
          5'($urandom_range(0, 7)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
